cnn_layer_accel_result_packer: RTL and testbench

Downstream stage of `cnn_layer_accel_quad`. It accepts the quad's 16-bit convolution results on the `result_valid`/`result_accept` handshake and packs eight results into each 128-bit word. Packed words are buffered in a small FIFO and presented on a ready/valid packet port toward the memory write path. The final word of a job is tagged with `pkt_last` and a lane-keep mask, and the block pulses `job_done` once the last word has been taken.

---
 rtl/cnn_layer_accel_result_packer.sv | 130 +++++++++++++
 tb/tb_cnn_layer_accel_result_packer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_result_packer.sv
// Packs 16-bit convolution results eight to a 128-bit word and queues them for the write path.
// Optional ReLU clamp of negative results: define CNN_LAYER_ACCEL_RESULT_PACKER_RELU_EN.
module cnn_layer_accel_result_packer #(
  parameter int C_FIFO_DEPTH = 4,
  parameter int C_CNT_WIDTH  = 24
) (
  input  logic                   clk_if,
  input  logic                   rst,
  input  logic                   job_start,
  input  logic [C_CNT_WIDTH-1:0] cfg_num_results,
  output logic                   busy,
  input  logic                   result_valid,
  output logic                   result_accept,
  input  logic [15:0]            result_data,
  output logic                   pkt_valid,
  input  logic                   pkt_ready,
  output logic [127:0]           pkt_data,
  output logic [7:0]             pkt_keep,
  output logic                   pkt_last,
  output logic                   job_done
);

  localparam int PTR_W = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FIFO_FULL = C_FIFO_DEPTH[PTR_W:0];

  typedef enum logic [1:0] {IDLE, PACK, DRAIN, DONE} state_t;

  typedef struct packed {
    logic         last;
    logic [7:0]   keep;
    logic [127:0] data;
  } entry_t;

  state_t                 state, state_nx;
  logic [C_CNT_WIDTH-1:0] remaining;
  logic [2:0]             lane_idx;
  logic [127:0]           staging;
  entry_t                 fifo_mem [C_FIFO_DEPTH];
  entry_t                 head;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W:0]         fifo_cnt;
  logic                   accept_fire, push, pop, is_last;
  logic [15:0]            lane_val;
  logic [127:0]           word_data;
  logic [7:0]             word_keep;

`ifdef CNN_LAYER_ACCEL_RESULT_PACKER_RELU_EN
  assign lane_val = result_data[15] ? 16'h0000 : result_data;
`else
  assign lane_val = result_data;
`endif

  assign result_accept = (state == PACK) && (fifo_cnt < FIFO_FULL);
  assign accept_fire   = result_accept && result_valid;
  assign is_last       = (remaining == C_CNT_WIDTH'(1));
  assign push          = accept_fire && ((lane_idx == 3'd7) || is_last);
  assign pop           = pkt_valid && pkt_ready;

  // Non-last pushes only happen at lane 7, so the thermometer mask covers both cases.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    word_data = staging;
    word_data[16*lane_idx +: 16] = lane_val;
    word_keep = '0;
    for (int i = 0; i < 8; i++) word_keep[i] = (3'(i) <= lane_idx);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (job_start) state_nx = (cfg_num_results == '0) ? DONE : PACK;
      PACK:    if (accept_fire && is_last) state_nx = DRAIN;
      DRAIN:   if (pop && pkt_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      lane_idx  <= '0;
      staging   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && job_start) begin
        remaining <= cfg_num_results;
        lane_idx  <= '0;
        staging   <= '0;
      end else if (accept_fire) begin
        remaining <= remaining - C_CNT_WIDTH'(1);
        lane_idx  <= lane_idx + 3'd1;
        staging   <= push ? '0 : word_data;
      end
    end
  end

  // NOTE: FIFO storage is not reset; the count gates every read, so stale entries are never seen.
  always_ff @(posedge clk_if) begin
    if (push) fifo_mem[wr_ptr] <= '{last: is_last, keep: word_keep, data: word_data};
  end

  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign head      = fifo_mem[rd_ptr];
  assign pkt_valid = (fifo_cnt != '0);
  assign pkt_data  = pkt_valid ? head.data : '0;
  assign pkt_keep  = pkt_valid ? head.keep : '0;
  assign pkt_last  = pkt_valid && head.last;
  assign job_done  = (state == DONE);
  // busy drops in the DONE cycle so it falls together with the job_done pulse.
  assign busy      = (state == PACK) || (state == DRAIN);

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// Directed bench for cnn_layer_accel_result_packer: packing, tails, backpressure, reset and ReLU.
module tb_cnn_layer_accel_result_packer;

  localparam int CW = 24;

  typedef logic [15:0] vq_t[$];
  typedef struct {
    logic [127:0] data;
    logic [7:0]   keep;
    logic         last;
    int           c;
  } word_t;

  logic          clk_if = 1'b0;
  logic          rst = 1'b1;
  logic          job_start = 1'b0;
  logic [CW-1:0] cfg_num_results = '0;
  logic          busy;
  logic          result_valid = 1'b0;
  logic          result_accept;
  logic [15:0]   result_data = '0;
  logic          pkt_valid;
  logic          pkt_ready = 1'b0;
  logic [127:0]  pkt_data;
  logic [7:0]    pkt_keep;
  logic          pkt_last;
  logic          job_done;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  word_t words[$];
  int    done_cnt = 0;
  int    done_cyc = -1;
  int    done_busy = 0;

  cnn_layer_accel_result_packer #(.C_FIFO_DEPTH(4), .C_CNT_WIDTH(CW)) dut (
    .clk_if(clk_if), .rst(rst), .job_start(job_start), .cfg_num_results(cfg_num_results),
    .busy(busy), .result_valid(result_valid), .result_accept(result_accept),
    .result_data(result_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_data(pkt_data), .pkt_keep(pkt_keep), .pkt_last(pkt_last), .job_done(job_done)
  );

  always #5 clk_if = ~clk_if;
  always @(posedge clk_if) cyc <= cyc + 1;

  // Monitor samples on the falling edge, half a cycle clear of the active edge.
  always @(negedge clk_if) begin
    if (!rst) begin
      if (pkt_valid && pkt_ready)
        words.push_back('{data: pkt_data, keep: pkt_keep, last: pkt_last, c: cyc});
      if (job_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy) done_busy++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  function automatic vq_t seq(input int base, input int n);
    vq_t q;
    for (int i = 0; i < n; i++) q.push_back(16'(base + i));
    return q;
  endfunction

  function automatic logic [127:0] pack(input vq_t v, input int start, input int n);
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < n; i++) d[16*i +: 16] = v[start+i];
    return d;
  endfunction

  task automatic tick();
    @(posedge clk_if);
    #1;
  endtask

  task automatic clear_mon();
    words.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    done_busy = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic start_job(input int n);
    job_start       = 1'b1;
    cfg_num_results = CW'(n);
    tick();
    job_start = 1'b0;
  endtask

  task automatic send(input vq_t v, output int stalls, output bit to);
    bit got;
    int w;
    stalls = 0;
    to     = 1'b0;
    foreach (v[i]) begin
      result_valid = 1'b1;
      result_data  = v[i];
      got = 1'b0;
      w   = 0;
      while (!got && w < 200) begin
        @(negedge clk_if);
        got = result_accept;
        if (!got) stalls++;
        w++;
        tick();
      end
      if (!got) to = 1'b1;
    end
    result_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    ok = (done_cnt > 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++;
    if ({busy, result_accept, pkt_valid, pkt_data, pkt_keep, pkt_last, job_done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b acc=%b vld=%b data=%h keep=%h last=%b done=%b want all 0",
               busy, result_accept, pkt_valid, pkt_data, pkt_keep, pkt_last, job_done);
    end
    do_reset();
    total++;
    if ({busy, result_accept, pkt_valid} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b acc=%b vld=%b want 000", busy, result_accept, pkt_valid);
    end
  endtask

  task automatic test_exact_multiple();
    vq_t v;
    int stalls;
    bit to, ok;
    clear_mon();
    pkt_ready = 1'b1;
    v = seq(0, 16);
    start_job(16);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL exact_busy: got %b want 1", busy); end
    send(v, stalls, to);
    wait_done(50, ok);
    total++;
    if (to || !ok) begin bad++; $display("FAIL exact_timeout: got to=%b done=%b want 0 1", to, ok); end
    total++;
    if (stalls != 0) begin bad++; $display("FAIL exact_stalls: got %0d want 0", stalls); end
    total++;
    if (words.size() != 2) begin bad++; $display("FAIL exact_words: got %0d want 2", words.size()); end
    if (words.size() == 2) begin
      total++;
      if (words[0].data !== pack(v, 0, 8) || words[0].keep !== 8'hFF || words[0].last !== 1'b0) begin
        bad++;
        $display("FAIL exact_word0: got %h/%h/%b want %h/ff/0", words[0].data, words[0].keep, words[0].last, pack(v, 0, 8));
      end
      total++;
      if (words[1].data !== pack(v, 8, 8) || words[1].keep !== 8'hFF || words[1].last !== 1'b1) begin
        bad++;
        $display("FAIL exact_word1: got %h/%h/%b want %h/ff/1", words[1].data, words[1].keep, words[1].last, pack(v, 8, 8));
      end
      total++;
      if (done_cyc != words[1].c + 1) begin
        bad++;
        $display("FAIL exact_done_timing: got cycle %0d want %0d", done_cyc, words[1].c + 1);
      end
    end
    repeat (3) tick();
    total++;
    if (done_cnt != 1 || done_busy != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL exact_done_pulse: got pulses=%0d busy_during=%0d busy=%b want 1 0 0", done_cnt, done_busy, busy);
    end
  endtask

  task automatic test_partial_tail();
    vq_t v;
    int stalls;
    bit to, ok;
    clear_mon();
    pkt_ready = 1'b1;
    v = seq(100, 11);
    start_job(11);
    send(v, stalls, to);
    wait_done(50, ok);
    total++;
    if (to || !ok || words.size() != 2) begin
      bad++;
      $display("FAIL tail_words: got to=%b done=%b n=%0d want 0 1 2", to, ok, words.size());
    end
    if (words.size() == 2) begin
      total++;
      if (words[0].data !== pack(v, 0, 8) || words[0].keep !== 8'hFF || words[0].last !== 1'b0) begin
        bad++;
        $display("FAIL tail_word0: got %h/%h/%b want %h/ff/0", words[0].data, words[0].keep, words[0].last, pack(v, 0, 8));
      end
      total++;
      if (words[1].data !== pack(v, 8, 3) || words[1].keep !== 8'h07 || words[1].last !== 1'b1) begin
        bad++;
        $display("FAIL tail_word1: got %h/%h/%b want %h/07/1", words[1].data, words[1].keep, words[1].last, pack(v, 8, 3));
      end
    end
  endtask

  task automatic test_backpressure();
    vq_t v;
    int idx, w;
    bit ok;
    clear_mon();
    pkt_ready = 1'b0;
    v = seq(500, 40);
    start_job(40);
    idx = 0;
    result_valid = 1'b1;
    repeat (50) begin
      result_data = v[idx];
      @(negedge clk_if);
      if (result_accept) idx++;
      tick();
    end
    @(negedge clk_if);
    total++;
    if (idx != 32 || result_accept !== 1'b0) begin
      bad++;
      $display("FAIL bp_accepted: got n=%0d acc=%b want 32 0", idx, result_accept);
    end
    total++;
    if (pkt_valid !== 1'b1 || pkt_data !== pack(v, 0, 8) || pkt_keep !== 8'hFF || pkt_last !== 1'b0) begin
      bad++;
      $display("FAIL bp_head_stable: got %b/%h/%h/%b want 1/%h/ff/0", pkt_valid, pkt_data, pkt_keep, pkt_last, pack(v, 0, 8));
    end
    tick();
    pkt_ready = 1'b1;
    w = 0;
    while (idx < 40 && w < 200) begin
      result_data = v[idx];
      @(negedge clk_if);
      if (result_accept) idx++;
      w++;
      tick();
    end
    result_valid = 1'b0;
    wait_done(50, ok);
    total++;
    if (idx != 40 || !ok || words.size() != 5) begin
      bad++;
      $display("FAIL bp_drain: got n=%0d done=%b words=%0d want 40 1 5", idx, ok, words.size());
    end
    for (int k = 0; k < words.size() && k < 5; k++) begin
      total++;
      if (words[k].data !== pack(v, 8*k, 8) || words[k].keep !== 8'hFF || words[k].last !== (k == 4)) begin
        bad++;
        $display("FAIL bp_word%0d: got %h/%h/%b want %h/ff/%b", k, words[k].data, words[k].keep, words[k].last,
                 pack(v, 8*k, 8), (k == 4));
      end
    end
  endtask

  task automatic test_zero_and_ignored();
    vq_t v;
    int stalls;
    bit to, ok;
    clear_mon();
    pkt_ready = 1'b1;
    start_job(0);
    total++;
    if (job_done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_done: got done=%b busy=%b want 1 0", job_done, busy);
    end
    tick();
    total++;
    if (job_done !== 1'b0 || pkt_valid !== 1'b0 || words.size() != 0) begin
      bad++;
      $display("FAIL zero_after: got done=%b vld=%b words=%0d want 0 0 0", job_done, pkt_valid, words.size());
    end
    clear_mon();
    v = seq(200, 16);
    start_job(16);
    send(v[0:2], stalls, to);
    start_job(4);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL ignored_busy: got %b want 1", busy); end
    send(v[3:15], stalls, to);
    wait_done(50, ok);
    total++;
    if (!ok || words.size() != 2) begin
      bad++;
      $display("FAIL ignored_words: got done=%b words=%0d want 1 2", ok, words.size());
    end
    if (words.size() == 2) begin
      total++;
      if (words[0].last !== 1'b0 || words[1].last !== 1'b1 || words[1].keep !== 8'hFF || words[1].data !== pack(v, 8, 8)) begin
        bad++;
        $display("FAIL ignored_word1: got %h/%h/%b (w0 last %b) want %h/ff/1", words[1].data, words[1].keep,
                 words[1].last, words[0].last, pack(v, 8, 8));
      end
    end
  endtask

  task automatic test_reset_mid_job();
    vq_t v;
    int stalls;
    bit to, ok;
    clear_mon();
    pkt_ready = 1'b1;
    start_job(16);
    send(seq(300, 5), stalls, to);
    total++;
    if (busy !== 1'b1 || result_accept !== 1'b1) begin
      bad++;
      $display("FAIL midrst_before: got busy=%b acc=%b want 1 1", busy, result_accept);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, result_accept, pkt_valid, pkt_data, pkt_keep, pkt_last, job_done} !== '0) begin
      bad++;
      $display("FAIL midrst_outputs: got busy=%b acc=%b vld=%b keep=%h last=%b done=%b want all 0",
               busy, result_accept, pkt_valid, pkt_keep, pkt_last, job_done);
    end
    tick();
    rst = 1'b0;
    tick();
    clear_mon();
    v = seq(400, 8);
    start_job(8);
    send(v, stalls, to);
    wait_done(50, ok);
    repeat (2) tick();
    total++;
    if (!ok || done_cnt != 1 || words.size() != 1) begin
      bad++;
      $display("FAIL midrst_new_job: got done=%b pulses=%0d words=%0d want 1 1 1", ok, done_cnt, words.size());
    end
    if (words.size() == 1) begin
      total++;
      if (words[0].data !== pack(v, 0, 8) || words[0].keep !== 8'hFF || words[0].last !== 1'b1) begin
        bad++;
        $display("FAIL midrst_word: got %h/%h/%b want %h/ff/1", words[0].data, words[0].keep, words[0].last, pack(v, 0, 8));
      end
    end
  endtask

  task automatic test_relu();
    vq_t v, e;
    int stalls;
    bit to, ok;
    clear_mon();
    pkt_ready = 1'b1;
    v = '{16'hFFFF, 16'h0005, 16'h8000, 16'h7FFF};
`ifdef CNN_LAYER_ACCEL_RESULT_PACKER_RELU_EN
    e = '{16'h0000, 16'h0005, 16'h0000, 16'h7FFF};
`else
    e = '{16'hFFFF, 16'h0005, 16'h8000, 16'h7FFF};
`endif
    start_job(4);
    send(v, stalls, to);
    wait_done(50, ok);
    total++;
    if (!ok || words.size() != 1) begin
      bad++;
      $display("FAIL relu_words: got done=%b words=%0d want 1 1", ok, words.size());
    end
    if (words.size() == 1) begin
      total++;
      if (words[0].data !== pack(e, 0, 4) || words[0].keep !== 8'h0F || words[0].last !== 1'b1) begin
        bad++;
        $display("FAIL relu_word: got %h/%h/%b want %h/0f/1", words[0].data, words[0].keep, words[0].last, pack(e, 0, 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact_multiple();
    test_partial_tail();
    test_backpressure();
    test_zero_and_ignored();
    test_reset_mid_job();
    test_relu();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
